// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation controller: operand/result
// widths, op codes (also the one-hot bit index of each unit) and the
// controller state encoding.
package alu_pkg;

   localparam int RES_W  = 16;
   localparam int OPND_W = 8;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_timeout_cnt.sv
// WAIT-state watchdog: 8-bit up-counter with synchronous clear and enable.
// o_tc flags the last cycle the controller is allowed to wait for done.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : zero the count (takes priority over i_en)
//   i_en           : count this cycle
//   o_tc           : count == TIMEOUT_CYCLES-1
module alu_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [7:0] r_cnt;

   // Holds at terminal count; the controller leaves WAIT on that cycle anyway.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_tc) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_tc = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_op_ctrl.sv
// Initiator side of the ALU start/done handshake. Takes one request at a
// time, pulses the selected unit's start for one cycle, waits for that
// unit's done (or a timeout) and holds the response until consumed.
// Ports:
//   i_clk, i_rst_n                    : clock, synchronous active-low reset
//   i_req_* / o_req_ready             : request valid/ready (op, a, b)
//   o_alu_a, o_alu_b                  : operands to all units
//   o_alu_start / i_alu_done          : one-hot start, per-unit done pulse
//   i_res_add/sub/mul/div             : unit results
//   o_rsp_* / i_rsp_ready             : response valid/ready
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ISSUE | one-cycle start pulse to unit[op], counter cleared
// WAIT  | watching only done[op], counting toward timeout
// RESP  | response held until rsp_ready
module alu_op_ctrl
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int NUM_UNITS      = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic [1:0]           i_req_op,
   input  logic [OPND_W-1:0]    i_req_a,
   input  logic [OPND_W-1:0]    i_req_b,
   output logic [OPND_W-1:0]    o_alu_a,
   output logic [OPND_W-1:0]    o_alu_b,
   output logic [NUM_UNITS-1:0] o_alu_start,
   input  logic [NUM_UNITS-1:0] i_alu_done,
   input  logic [RES_W-1:0]     i_res_add,
   input  logic [RES_W-1:0]     i_res_sub,
   input  logic [RES_W-1:0]     i_res_mul,
   input  logic [RES_W-1:0]     i_res_div,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [RES_W-1:0]     o_rsp_result,
   output logic [1:0]           o_rsp_op,
   output logic                 o_rsp_timeout
);

   state_t               r_state;
   logic                 r_req_ready;
   logic [1:0]           r_op;
   logic [OPND_W-1:0]    r_alu_a;
   logic [OPND_W-1:0]    r_alu_b;
   logic [NUM_UNITS-1:0] r_start;
   logic                 r_rsp_valid;
   logic [RES_W-1:0]     r_rsp_result;
   logic [1:0]           r_rsp_op;
   logic                 r_rsp_timeout;

   logic                 w_tc;
   logic                 w_unit_done;
   logic [RES_W-1:0]     w_unit_res;

   alu_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (r_state == ST_ISSUE),
      .i_en    (r_state == ST_WAIT),
      .o_tc    (w_tc)
   );

   // Only the unit that was started may complete the op.
   assign w_unit_done = i_alu_done[r_op];

   always_comb begin
      w_unit_res = '0;
      case (r_op)
         OP_ADD:  w_unit_res = i_res_add;
         OP_SUB:  w_unit_res = i_res_sub;
         OP_MUL:  w_unit_res = i_res_mul;
         OP_DIV:  w_unit_res = i_res_div;
         default: w_unit_res = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_req_ready   <= 1'b0;
         r_op          <= OP_ADD;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_start       <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_op      <= OP_ADD;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_start <= '0;
         case (r_state)
            ST_IDLE: begin
               r_req_ready <= 1'b1;
               if (i_req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_op        <= i_req_op;
                  r_alu_a     <= i_req_a;
                  r_alu_b     <= i_req_b;
                  // Start is registered here so it is high exactly during ISSUE.
                  r_start     <= NUM_UNITS'(1) << i_req_op;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Done on the terminal-count cycle still counts as a completion.
               if (w_unit_done) begin
                  r_rsp_result  <= w_unit_res;
                  r_rsp_timeout <= 1'b0;
                  r_rsp_op      <= r_op;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= ST_RESP;
               end else if (w_tc) begin
                  r_rsp_result  <= '0;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_op      <= r_op;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_req_ready   = r_req_ready;
   assign o_alu_a       = r_alu_a;
   assign o_alu_b       = r_alu_b;
   assign o_alu_start   = r_start;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_result  = r_rsp_result;
   assign o_rsp_op      = r_rsp_op;
   assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/alu_op_ctrl.md
Name: alu_op_ctrl

Overview:
Initiator side of the ALU start/done handshake. Accepts operation requests (op, a, b) on a valid/ready interface and issues each request as a single-cycle start pulse to the selected arithmetic unit (add, sub, mul, div). It then waits for that unit's done pulse, captures the sign-extended 16-bit result and presents it on a valid/ready response interface. The block sits between the top-level datapath/control and the alu_* arithmetic units, with one operation in flight at a time.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before the op is aborted with rsp_timeout=1 (legal range 4..255)
NUM_UNITS, 4, number of arithmetic units; one-hot start/done width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_op  input  2  0=ADD 1=SUB 2=MUL 3=DIV
req_a  input  8  signed operand A
req_b  input  8  signed operand B
alu_a  output  8  operand A to all units, held stable from ISSUE until the next accept
alu_b  output  8  operand B to all units, held stable from ISSUE until the next accept
alu_start  output  NUM_UNITS  one-hot start, bit index = op code
alu_done  input  NUM_UNITS  per-unit done pulse
res_add, res_sub, res_mul, res_div  input  16 each  signed unit results
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  16  signed result; 0 on timeout
rsp_op  output  2  op code of this response
rsp_timeout  output  1  op aborted, no done seen

Behaviour:
- Reset: sampled on clk edge when rst_n=0. State=IDLE, req_ready=0 in the reset cycle, alu_start=0, alu_a=alu_b=0, rsp_valid=0, rsp_result=0, rsp_op=0, rsp_timeout=0, timeout counter=0.
- Reset mid-operation: abandons the op, no response. A late alu_done after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, register op/a/b and go to ISSUE.
- ISSUE: exactly one cycle. alu_start[op]=1, all other bits 0. Go to WAIT and clear the counter.
- start is never held for more than one cycle. Units re-trigger if start stays high after done.
- WAIT: counter increments each cycle. Sample only alu_done[op]; done bits of other units are ignored.
  - alu_done[op]=1: capture the matching res_* into rsp_result, rsp_timeout=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: rsp_result=0, rsp_timeout=1, go to RESP.
  - done arriving on that same cycle wins over timeout.
- RESP: rsp_valid=1; rsp_result, rsp_op and rsp_timeout are held stable. On rsp_ready, go to IDLE and drop rsp_valid.
- No request is accepted until the response is consumed; req_ready=0 outside IDLE.
- Latency, ADD unit (1-cycle latch + 1-cycle compute):
  - accept at edge E0; start high in cycle E0..E1
  - unit latches at E1; done high in cycle E2..E3
  - rsp_valid high from E3, so accept-to-response = 3 clk edges
- Back-to-back: with rsp_ready held 1, throughput is one op per 5 cycles for ADD (IDLE cycle included).
- Result width: units return 16-bit signed values, passed through unmodified. No truncation or saturation in this block.
- alu_done pulses in IDLE, ISSUE or RESP are ignored, with no state change.

Decomposition:
- Shared package alu_pkg:
  - op code constants OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_DIV=2'd3
  - state encoding for IDLE, ISSUE, WAIT, RESP
  - RES_W=16 and OPND_W=8
- One sub-module: alu_timeout_cnt, an 8-bit counter with clear, enable and terminal-count compare against TIMEOUT_CYCLES-1.

Test Plan:
1. ADD: a=8'sd100, b=8'sd27, ADD model behind alu_done[0] -> one-cycle alu_start=4'b0001; rsp_result=16'sh007F, rsp_op=0, rsp_timeout=0; rsp_valid 3 edges after accept.
2. ADD overflow wrap: a=8'sd100, b=8'sd100 -> rsp_result=16'shFFC8 (-56 sign-extended, passed through); a=-8'sd1, b=-8'sd1 -> 16'shFFFE.
3. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable and req_ready=0 throughout; a second request held on req_valid is accepted only the cycle after rsp_ready=1.
4. Timeout: MUL op, model never asserts done -> rsp_timeout=1, rsp_result=0 at cycle TIMEOUT_CYCLES after ISSUE. A stray alu_done[2] afterwards is ignored.
5. Wrong-unit done: SUB op (start=4'b0010); inject alu_done[0] first -> ignored; alu_done[1] two cycles later with res_sub=16'shFFF6 -> rsp_result=16'shFFF6.
6. Reset mid-WAIT: rst_n=0 for one cycle during WAIT -> all outputs at reset values next cycle, no rsp_valid. The unit's later done is ignored, and a fresh ADD then completes correctly.
